// File: rtl/mb_rx_flit_ctrl.sv
// Mainband receive flit-path controller: link sequencing, downstream slot
// occupancy tracking, batched/timed credit return and protocol error flags.
module mb_rx_flit_ctrl #(
   parameter int CREDITS       = 4,
   parameter int RET_THRESHOLD = 2,
   parameter int RET_TIMEOUT   = 16,
   parameter int FLUSH_CYCLES  = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             link_en_i,
   input  logic                             flit_valid_i,
   input  logic                             flit_pop_i,
   input  logic                             err_clr_i,
   output logic                             rx_reset_o,
   output logic                             link_active_o,
   output logic [$clog2(CREDITS+1)-1:0]     occupancy_o,
   output logic                             credit_ret_o,
   output logic [$clog2(CREDITS+1)-1:0]     credit_ret_cnt_o,
   output logic                             overflow_err_o,
   output logic                             underflow_err_o
);

   localparam int CW = $clog2(CREDITS + 1);
   localparam int TW = $clog2(RET_TIMEOUT + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   localparam logic [1:0] ST_DISABLED = 2'd0;
   localparam logic [1:0] ST_FLUSH    = 2'd1;
   localparam logic [1:0] ST_ACTIVE   = 2'd2;
   localparam logic [1:0] ST_DRAIN    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] pend_q, pend_d, pend_base;
   logic [TW-1:0] timer_q, timer_d;
   logic          rx_reset_q, link_active_q;
   logic          cret_q;
   logic [CW-1:0] cret_cnt_q, cret_cnt_d;
   logic          ovf_q, unf_q;
   logic          ovf_new, unf_new, freed, fire, grant;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      occ_d       = occ_q;
      pend_d      = pend_q;
      pend_base   = pend_q;
      timer_d     = timer_q;
      ovf_new     = 1'b0;
      unf_new     = 1'b0;
      freed       = 1'b0;
      fire        = 1'b0;
      grant       = 1'b0;

      if (state_q == ST_ACTIVE || state_q == ST_DRAIN) begin
         case ({flit_valid_i, flit_pop_i})
            2'b10: begin
               if (occ_q < CW'(CREDITS)) occ_d = occ_q + 1'b1;
               else                      ovf_new = 1'b1;
            end
            2'b01: begin
               if (occ_q != '0) begin
                  occ_d = occ_q - 1'b1;
                  freed = 1'b1;
               end else begin
                  unf_new = 1'b1;
               end
            end
            2'b11: begin
               if (occ_q != '0) freed   = 1'b1;
               else             unf_new = 1'b1;
            end
            default: ;
         endcase
      end

      case (state_q)
         ST_DISABLED: begin
            if (link_en_i) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            occ_d   = '0;
            pend_d  = '0;
            timer_d = '0;
            if (!link_en_i) begin
               state_d = ST_DISABLED;
            end else if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
               state_d = ST_ACTIVE;
               grant   = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!link_en_i) begin
               // Leaving ACTIVE: pending credits are dropped, so no strobe may land in DRAIN.
               state_d = ST_DRAIN;
               pend_d  = '0;
               timer_d = '0;
            end else begin
               // Grant is only issued on the FLUSH->ACTIVE edge, so it never collides with fire.
               fire = (pend_q >= CW'(RET_THRESHOLD)) ||
                      ((pend_q != '0) && (timer_q == TW'(RET_TIMEOUT - 1)));
               pend_base = fire ? '0 : pend_q;
               if (pend_base == CW'(CREDITS)) pend_d = pend_base;
               else                           pend_d = pend_base + CW'(freed);
               timer_d = (fire || pend_q == '0) ? '0 : timer_q + 1'b1;
            end
         end
         default: begin
            pend_d  = '0;
            timer_d = '0;
            if (occ_q == '0 && !flit_valid_i) state_d = ST_DISABLED;
         end
      endcase

      if (grant)     cret_cnt_d = CW'(CREDITS);
      else if (fire) cret_cnt_d = pend_q;
      else           cret_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_DISABLED;
         flush_cnt_q   <= '0;
         occ_q         <= '0;
         pend_q        <= '0;
         timer_q       <= '0;
         rx_reset_q    <= 1'b1;
         link_active_q <= 1'b0;
         cret_q        <= 1'b0;
         cret_cnt_q    <= '0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         occ_q         <= occ_d;
         pend_q        <= pend_d;
         timer_q       <= timer_d;
         rx_reset_q    <= (state_d == ST_DISABLED) || (state_d == ST_FLUSH);
         link_active_q <= (state_d == ST_ACTIVE);
         cret_q        <= grant | fire;
         cret_cnt_q    <= cret_cnt_d;
         ovf_q         <= (ovf_q & ~err_clr_i) | ovf_new;
         unf_q         <= (unf_q & ~err_clr_i) | unf_new;
      end
   end

   assign rx_reset_o       = rx_reset_q;
   assign link_active_o    = link_active_q;
   assign occupancy_o      = occ_q;
   assign credit_ret_o     = cret_q;
   assign credit_ret_cnt_o = cret_cnt_q;
   assign overflow_err_o   = ovf_q;
   assign underflow_err_o  = unf_q;

endmodule

// File: doc/mb_rx_flit_ctrl.md
Name: mb_rx_flit_ctrl

Overview:
- Clk-domain controller for the mainband receive flit path. It sequences the receiver through reset, flush, active and drain. It tracks flit-slot occupancy of the downstream flit store from the receiver's flit valid pulses and consumer pops.
- It returns flit credits to the far-end transmitter (via sideband logic) in batches or on timeout, and flags overflow/underflow protocol errors.

Parameters:
- CREDITS, 4, flit slots advertised to the transmitter; equals receiver flit buffer depth; power of 2, >=2.
- RET_THRESHOLD, 2, pending freed slots that trigger an immediate credit return; 1..CREDITS.
- RET_TIMEOUT, 16, cycles a non-zero pending count may wait before a forced return; >=1.
- FLUSH_CYCLES, 8, cycles rx_reset_o is held in FLUSH; >=1.

Ports:
- clk  input  1  single block clock; all logic on posedge.
- reset  input  1  asynchronous, active-low; 0 resets all state.
- link_en_i  input  1  link-training enable for mainband receive.
- flit_valid_i  input  1  one-cycle pulse per complete 64B flit from the receiver.
- flit_pop_i  input  1  consumer frees one flit slot.
- err_clr_i  input  1  clears sticky error flags.
- rx_reset_o  output  1  active-high reset to the receiver datapath.
- link_active_o  output  1  high in ACTIVE only.
- occupancy_o  output  $clog2(CREDITS+1)  flits held downstream.
- credit_ret_o  output  1  one-cycle credit-return strobe.
- credit_ret_cnt_o  output  $clog2(CREDITS+1)  credits returned with the strobe; 0 when strobe low.
- overflow_err_o  output  1  sticky: flit arrived with no free slot.
- underflow_err_o  output  1  sticky: pop with occupancy 0.

Behaviour:
- Reset values: state=DISABLED, rx_reset_o=1, link_active_o=0, occupancy_o=0, credit_ret_o=0, credit_ret_cnt_o=0, both errors=0. Internal pending=0 and timer=0. All outputs are registered.
- DISABLED: rx_reset_o=1. flit_valid_i and flit_pop_i are ignored. When link_en_i=1, go to FLUSH next cycle.
- FLUSH:
  - rx_reset_o=1. Count FLUSH_CYCLES cycles, clearing occupancy, pending and timer.
  - Then go to ACTIVE.
  - If link_en_i drops during FLUSH, go to DISABLED.
- ACTIVE:
  - rx_reset_o=0, link_active_o=1.
  - On the first ACTIVE cycle, assert credit_ret_o with credit_ret_cnt_o=CREDITS (initial grant).
  - If link_en_i=0, go to DRAIN.
- DRAIN:
  - rx_reset_o=0, link_active_o=0. Arrivals and pops are still tracked, and errors still detected.
  - No credit returns; pending is discarded.
  - When occupancy==0 and flit_valid_i=0, go to DISABLED.
  - If link_en_i reasserts, keep draining; re-entry happens via DISABLED->FLUSH.
- Occupancy update each cycle, ACTIVE/DRAIN only:
  - valid only, occupancy<CREDITS: occupancy+1.
  - valid only, occupancy==CREDITS: flit dropped, occupancy unchanged, overflow_err_o=1.
  - pop only, occupancy>0: occupancy-1, slot freed.
  - pop only, occupancy==0: ignored, underflow_err_o=1.
  - valid and pop, occupancy>0: occupancy unchanged, one slot freed (full case legal, no error).
  - valid and pop, occupancy==0: occupancy stays 0 net (arrival then pop), underflow_err_o=1, no slot freed.
- Credit return, ACTIVE only:
  - Each freed slot increments pending, saturating at CREDITS.
  - Timer counts cycles while pending>0 and resets to 0 when pending==0 or on a return.
  - Return fires when pending>=RET_THRESHOLD, or when pending>0 and timer==RET_TIMEOUT-1.
  - On return, credit_ret_o=1 next cycle with credit_ret_cnt_o equal to pending at evaluation time. Pending is reduced by that amount; a slot freed in the same cycle remains pending.
  - The initial grant cycle suppresses any other return that cycle; that return is deferred one cycle.
  - Invariant: occupancy + pending + far-end credits == CREDITS when no error.
- Errors: sticky until err_clr_i=1, which clears them next cycle. A new error in the clear cycle wins (flag stays 1).
- Reset mid-operation: all state returns to reset values immediately (asynchronous), with no credit strobe.

Test Plan:
- Bring-up: reset release, link_en_i=1 -> rx_reset_o=1 for FLUSH_CYCLES=8 cycles, then ACTIVE; one credit_ret_o pulse with cnt=4; link_active_o=1.
- Fill and overflow: 4 flit_valid_i pulses -> occupancy_o=4; 5th pulse -> occupancy stays 4, overflow_err_o=1; err_clr_i -> 0.
- Threshold return: occupancy 4, two pops -> occupancy 2, credit_ret_o with cnt=2 one cycle after second pop.
- Timeout return: one pop, no further pops -> credit_ret_o cnt=1 exactly RET_TIMEOUT=16 cycles later.
- Simultaneous: occupancy 4, valid+pop same cycle -> occupancy 4, no overflow, pending+1. At occupancy 0, valid+pop -> occupancy 0, underflow_err_o=1.
- Drain and async reset: link_en_i=0 at occupancy 3 -> DRAIN, no credit strobes; 3 pops -> DISABLED, rx_reset_o=1. Assert reset mid-ACTIVE -> all outputs to reset values immediately.
